// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port BRAM; define ROUND_ROBIN_EN for alternating tie-break.
// Latency: request sampled in IDLE at N, BRAM command at N+1, ack at N+2, back in IDLE at N+3.
// Backpressure: requests are held by the requester until ack; losers wait for the next IDLE cycle.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wmask,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    output logic              mem_rstrb,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0] state;
    logic       owner_d;   // 1 = data port owns the transaction; also serves as last-grant
    logic       grant_d;

    always_comb begin
        grant_d = d_req;
`ifdef ROUND_ROBIN_EN
        if (i_req && d_req) begin
            grant_d = !owner_d;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            owner_d   <= 1'b1;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= 4'h0;
            mem_rstrb <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    if (i_req || d_req) begin
                        owner_d   <= grant_d;
                        mem_addr  <= grant_d ? d_addr : i_addr;
                        mem_wdata <= grant_d ? d_wdata : 32'h0;
                        mem_wmask <= grant_d ? d_wmask : 4'h0;
                        // fetches are always reads; a data access reads only with an empty mask
                        mem_rstrb <= !grant_d || (d_wmask == 4'h0);
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mem_rstrb <= 1'b0;
                    mem_wmask <= 4'h0;
                    i_ack     <= !owner_d;
                    d_ack     <= owner_d;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    i_ack     <= 1'b0;
                    d_ack     <= 1'b0;
                    mem_rstrb <= 1'b0;
                    mem_wmask <= 4'h0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    // BRAM data lands in the WAIT cycle, which is exactly when the owner's ack is high
    assign i_rdata = i_ack ? mem_rdata : 32'h0;
    assign d_rdata = d_ack ? mem_rdata : 32'h0;
    assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboarded BRAM commands and acks with cycle-exact timing.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        i_req;
    logic [7:0]  i_addr = 8'h0;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic [7:0]  d_addr = 8'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [3:0]  d_wmask = 4'h0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy;

    mem_arbiter #(.ADDR_W(8)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail = 0;

    // requests are level signals derived from issue/complete counters so each has one writer
    int i_set = 0, i_done = 0, i_abort = 0;
    int d_set = 0, d_done = 0;
    bit hold_d = 1'b0;
    assign i_req = (i_set != i_done + i_abort);
    assign d_req = (d_set != d_done);

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t cmd_q[$];
    exp_t ack_q[$];
    logic [31:0] ref_mem [256];

    function automatic logic [31:0] init_word(input int a);
        return (a == 5) ? 32'h00108093 : (32'hA5A50000 | a);
    endfunction

    // BRAM stand-in: one-cycle read latency, byte-masked writes
    logic [31:0] bram [256];
    logic        bram_init = 1'b0;
    always @(posedge clk) begin
        if (!bram_init) begin
            for (int k = 0; k < 256; k++) bram[k] <= init_word(k);
            bram_init <= 1'b1;
        end else begin
            if (mem_rstrb) mem_rdata <= bram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_txn(input bit is_d, input logic [7:0] addr, input logic [31:0] wdata,
                              input logic [3:0] mask, input int ack_cyc, input bit with_ack);
        exp_t e;
        e.is_d  = is_d;
        e.wr    = (mask != 4'h0);
        e.addr  = addr;
        e.wdata = wdata;
        e.mask  = mask;
        e.rdata = ref_mem[addr];
        e.cyc   = ack_cyc - 1;
        cmd_q.push_back(e);
        e.cyc   = ack_cyc;
        if (with_ack) ack_q.push_back(e);
        for (int b = 0; b < 4; b++)
            if (mask[b]) ref_mem[addr][8*b +: 8] = wdata[8*b +: 8];
    endtask

    task automatic drive_i(input logic [7:0] addr);
        i_addr = addr;
        i_set++;
    endtask

    task automatic drive_d(input logic [7:0] addr, input logic [31:0] wdata, input logic [3:0] mask);
        d_addr  = addr;
        d_wdata = wdata;
        d_wmask = mask;
        d_set++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_i_ack"}, i_ack, 0);
        chk({tag, "_d_ack"}, d_ack, 0);
        chk({tag, "_mem_rstrb"}, mem_rstrb, 0);
        chk({tag, "_mem_wmask"}, mem_wmask, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // returns at negedge+2 of the first IDLE cycle after all traffic has drained
    task automatic wait_idle();
        int n = 0;
        while ((cmd_q.size() != 0 || ack_q.size() != 0 || i_req || d_req) && n < 60) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 60) chk("drain_timeout", cmd_q.size() + ack_q.size(), 0);
        @(negedge clk);
        #2;
        chk("busy_idle", busy, 0);
    endtask

    // monitor: compares every BRAM command and every ack against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (mem_rstrb || mem_wmask != 4'h0) chk("rstrb_wmask_exclusive", mem_rstrb && (mem_wmask != 4'h0), 0);
        if (i_ack || d_ack) chk("ack_exclusive", i_ack && d_ack, 0);
        if (mem_rstrb || mem_wmask != 4'h0) begin
            if (cmd_q.size() == 0) begin
                chk("unexpected_cmd_addr", mem_addr, 8'hxx);
            end else begin
                e = cmd_q.pop_front();
                chk("cmd_cycle", cyc, e.cyc);
                chk("cmd_addr", mem_addr, e.addr);
                chk("cmd_rstrb", mem_rstrb, !e.wr);
                chk("cmd_wmask", mem_wmask, e.mask);
                if (e.wr) chk("cmd_wdata", mem_wdata, e.wdata);
                chk("busy_issue", busy, 1);
            end
        end
        if (i_ack || d_ack) begin
            if (ack_q.size() == 0) begin
                chk("unexpected_ack", {i_ack, d_ack}, 0);
            end else begin
                e = ack_q.pop_front();
                chk("ack_port_is_d", d_ack, e.is_d);
                chk("ack_cycle", cyc, e.cyc);
                if (!e.wr) chk("ack_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
                chk("busy_wait", busy, 1);
            end
            if (i_ack) i_done++;
            if (d_ack && !hold_d) d_done++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk_reset_outputs("reset");
        resetn = 1'b1;
        @(negedge clk);
        #2;

        // tie straight after reset
        n = cyc;
        drive_i(8'd5);
        drive_d(8'd7, 32'h0, 4'h0);
`ifdef ROUND_ROBIN_EN
        expect_txn(1'b0, 8'd5, 32'h0, 4'h0, n + 2, 1'b1);
        expect_txn(1'b1, 8'd7, 32'h0, 4'h0, n + 5, 1'b1);
`else
        expect_txn(1'b1, 8'd7, 32'h0, 4'h0, n + 2, 1'b1);
        expect_txn(1'b0, 8'd5, 32'h0, 4'h0, n + 5, 1'b1);
`endif
        wait_idle();

        // fetch from address 5
        n = cyc;
        drive_i(8'd5);
        expect_txn(1'b0, 8'd5, 32'h0, 4'h0, n + 2, 1'b1);
        wait_idle();

        // full-word store, then load it back
        n = cyc;
        drive_d(8'd4, 32'hDEADBEEF, 4'hF);
        expect_txn(1'b1, 8'd4, 32'hDEADBEEF, 4'hF, n + 2, 1'b1);
        wait_idle();
        n = cyc;
        drive_d(8'd4, 32'h0, 4'h0);
        expect_txn(1'b1, 8'd4, 32'h0, 4'h0, n + 2, 1'b1);
        wait_idle();

        // partial store, then fetch the merged word
        n = cyc;
        drive_d(8'd4, 32'h11223344, 4'b0101);
        expect_txn(1'b1, 8'd4, 32'h11223344, 4'b0101, n + 2, 1'b1);
        wait_idle();
        n = cyc;
        drive_i(8'd4);
        expect_txn(1'b0, 8'd4, 32'h0, 4'h0, n + 2, 1'b1);
        wait_idle();

        // data request raised while a fetch is in flight
        n = cyc;
        drive_i(8'd5);
        expect_txn(1'b0, 8'd5, 32'h0, 4'h0, n + 2, 1'b1);
        @(negedge clk);
        #2;
        drive_d(8'd9, 32'h0, 4'h0);
        expect_txn(1'b1, 8'd9, 32'h0, 4'h0, n + 5, 1'b1);
        wait_idle();

        // reset during ISSUE aborts without an ack
        n = cyc;
        drive_i(8'd9);
        expect_txn(1'b0, 8'd9, 32'h0, 4'h0, n + 2, 1'b0);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        @(negedge clk);
        #2;
        chk_reset_outputs("abort");
        i_abort++;
        resetn = 1'b1;
        wait_idle();

`ifndef ROUND_ROBIN_EN
        // continuous data requests starve fetch until data lets go
        n = cyc;
        hold_d = 1'b1;
        drive_i(8'd3);
        drive_d(8'd7, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) expect_txn(1'b1, 8'd7, 32'h0, 4'h0, n + 2 + 3 * k, 1'b1);
        expect_txn(1'b0, 8'd3, 32'h0, 4'h0, n + 14, 1'b1);
        for (int k = 0; k < 20 && cyc < n + 10; k++) begin
            @(negedge clk);
            #2;
        end
        hold_d = 1'b0;
        wait_idle();
`endif

        chk("cmd_q_drained", cmd_q.size(), 0);
        chk("ack_q_drained", ack_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width (8 gives 256 words).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 resetn  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 i_req  input  1  fetch port request, held until i_ack.
REQ-005 i_addr  input  ADDR_W  fetch word address, stable while i_req high.
REQ-006 i_rdata  output  32  fetch read data, valid only while i_ack high.
REQ-007 i_ack  output  1  fetch completion, one-cycle pulse.
REQ-008 d_req  input  1  data port request (load/store), held until d_ack.
REQ-009 d_addr  input  ADDR_W  data word address, stable while d_req high.
REQ-010 d_wdata  input  32  store data, stable while d_req high.
REQ-011 d_wmask  input  4  byte write enables; 4'b0000 means read.
REQ-012 d_rdata  output  32  load data, valid only while d_ack high.
REQ-013 d_ack  output  1  data completion, one-cycle pulse.
REQ-014 mem_addr  output  ADDR_W  single-port BRAM word address (registered).
REQ-015 mem_wdata  output  32  BRAM write data (registered).
REQ-016 mem_wmask  output  4  BRAM byte write enables, nonzero for exactly one cycle per store.
REQ-017 mem_rstrb  output  1  BRAM read strobe, high for exactly one cycle per read.
REQ-018 mem_rdata  input  32  BRAM read data, valid the cycle after mem_rstrb.
REQ-019 busy  output  1  high whenever the state is not IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-021 IDLE: if any request is high, latch the winner as owner, register its addr/wdata/wmask onto mem_*, and go to ISSUE; otherwise stay.
REQ-022 ISSUE: drive mem_rstrb=1 for reads or mem_wmask=request mask for stores, both for exactly one cycle, then go to WAIT.
REQ-023 WAIT: assert the owner's ack for one cycle, with its rdata = mem_rdata, then go to IDLE.
REQ-024 Latency SHALL be: request sampled in IDLE at cycle N, command at N+1, ack at N+2, IDLE at N+3; at most one transaction per 3 cycles.
REQ-025 A fixed-priority tie (i_req and d_req both high in IDLE) SHALL grant data.
REQ-026 A request raised while busy SHALL be held off and arbitrated at the next IDLE cycle; no request is dropped.
REQ-027 Store acks SHALL still pulse in WAIT; d_rdata during a store ack is don't-care.
REQ-028 The non-owner ack SHALL stay 0; i_ack and d_ack are never high together.
REQ-029 mem_rstrb and mem_wmask SHALL never be nonzero together, and SHALL be 0 outside ISSUE.
REQ-030 Requesters drop req in the cycle after ack; a req still high at N+3 is treated as a new request.
REQ-031 With fixed priority, continuous d_req MAY starve fetch; this is accepted behaviour.

Reset
REQ-032 While resetn=0 at a clk edge: state=IDLE, i_ack=d_ack=0, mem_rstrb=0, mem_wmask=0, mem_addr=0, mem_wdata=0, busy=0, owner=data.
REQ-033 Reset in ISSUE or WAIT SHALL abort the transaction with no ack; the requester re-requests.

Configuration
REQ-034 Macro ROUND_ROBIN_EN defined: ties SHALL go to the port not granted last (reset last-grant=data, so the first tie goes to fetch); non-tie grants are unchanged.
REQ-035 Macro ROUND_ROBIN_EN undefined: fixed data-over-fetch priority per REQ-025.

Verification
REQ-036 i_req, i_addr=5, mem returns 0x00108093 -> mem_rstrb at N+1 with mem_addr=5; i_ack at N+2 with i_rdata=0x00108093.
REQ-037 d_req, d_addr=4, d_wmask=4'hF, d_wdata=0xDEADBEEF -> mem_wmask=4'hF for one cycle at N+1; d_ack at N+2; mem_rstrb stays 0.
REQ-038 i_req and d_req both high at N -> without the macro: d_ack at N+2 and i_ack at N+5; with ROUND_ROBIN_EN: i_ack at N+2 and d_ack at N+5.
REQ-039 resetn=0 asserted in the ISSUE cycle -> no ack, all outputs at reset values the next cycle, busy=0.
REQ-040 d_req held continuously with i_req high, without the macro -> only d_ack pulses every 3 cycles, and i_ack never occurs.
